wb_arbiter: RTL

//  Writeback arbiter and pending-write scoreboard in front of the register file's single write port.

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results (strict priority) and buffered long-latency results share one
// registered regfile write port; a pending-write scoreboard flags RAW hazards. Optional macro: WB_BYPASS_EN.
module wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_addr1,
  input  logic [4:0]      chk_addr2,
  output logic            busy1,
  output logic            busy2,
  output logic            fwd1_valid,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd_data,
  output logic            w_ena,
  output logic [4:0]      w_addr,
  output logic [XLEN-1:0] w_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Handshake: an LSU result transfers on a cycle where lsu_valid && lsu_ready at posedge clk.
  logic [4:0]      rd_mem_q   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pend_q, pend_d;
  logic            w_ena_q, w_ena_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;

  logic            full, empty, push, pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign lsu_ready = !rst && !full;
  assign push      = lsu_valid && lsu_ready;
  assign pop       = !rst && !alu_valid && !empty;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    pend_d   = pend_q;
    w_ena_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (alu_valid) begin
      w_ena_d  = (alu_rd != 5'd0);
      w_addr_d = alu_rd;
      w_data_d = alu_data;
    end else if (pop) begin
      rd_ptr_d         = rd_ptr_q + PW'(1);
      w_ena_d          = (head_rd != 5'd0);
      w_addr_d         = head_rd;
      w_data_d         = head_data;
      pend_d[head_rd]  = 1'b0;
    end
    // Issue is applied after the pop clear so a same-cycle set wins.
    if (iss_valid) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= lsu_rd;
      data_mem_q[wr_ptr_q] <= lsu_data;
    end
  end

  assign w_ena  = w_ena_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

`ifdef WB_BYPASS_EN
  // Forward the value being written this cycle, before the regfile can return it.
  assign fwd1_valid = w_ena_q && (w_addr_q == chk_addr1) && (chk_addr1 != 5'd0);
  assign fwd2_valid = w_ena_q && (w_addr_q == chk_addr2) && (chk_addr2 != 5'd0);
  assign fwd_data   = w_data_q;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd_data   = '0;
`endif

  assign busy1 = pend_q[chk_addr1] && !fwd1_valid;
  assign busy2 = pend_q[chk_addr2] && !fwd2_valid;
endmodule
